// File: rtl/pdm_dac_pkg.sv
// Shared sizing helpers for the PDM-to-DAC adapter: the CIC datapath width,
// the requantiser shift, and the warm-up counter width.
package pdm_dac_pkg;

   localparam int unsigned WARMUP_W = 2;

   function automatic int unsigned cic_width(input int unsigned order,
                                             input int unsigned r_log2);
      return order * r_log2 + 1;
   endfunction

   function automatic int unsigned cic_shift(input int unsigned order,
                                             input int unsigned r_log2,
                                             input int unsigned dac_w);
      return order * r_log2 - dac_w;
   endfunction

endpackage

// File: rtl/pdm_cic_channel.sv
// One PDM channel: ORDER-stage CIC decimator, saturating requantiser and
// sticky clip flag; first-order error feedback under PDM_DAC_NOISE_SHAPE_EN.
module pdm_cic_channel
   import pdm_dac_pkg::*;
#(
   parameter int unsigned DAC_W  = 4,
   parameter int unsigned R_LOG2 = 4,
   parameter int unsigned ORDER  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_pdm,
   input  logic             i_event,
   input  logic             i_emit,
   output logic [DAC_W-1:0] o_dac,
   output logic             o_clip
);

   localparam int unsigned W = cic_width(ORDER, R_LOG2);
   localparam int unsigned S = cic_shift(ORDER, R_LOG2, DAC_W);

   logic [W-1:0]     r_integ     [ORDER];
   logic [W-1:0]     r_comb_dly  [ORDER];
   logic [W-1:0]     w_integ_nxt [ORDER];
   logic [W-1:0]     w_comb      [ORDER+1];
   logic [W-1:0]     w_v;
   logic [DAC_W:0]   w_q;
   logic             w_sat;
   logic [DAC_W-1:0] w_dac;
   logic [DAC_W-1:0] r_dac;
   logic             r_clip;

   // Integrators ripple within the cycle so the comb sees this sample's update.
   always_comb begin
      w_integ_nxt    = '{default: '0};
      w_integ_nxt[0] = r_integ[0] + {{(W-1){1'b0}}, i_pdm};
      for (int unsigned k = 1; k < ORDER; k++) begin
         w_integ_nxt[k] = r_integ[k] + w_integ_nxt[k-1];
      end
   end

   always_comb begin
      w_comb    = '{default: '0};
      w_comb[0] = w_integ_nxt[ORDER-1];
      for (int unsigned k = 0; k < ORDER; k++) begin
         w_comb[k+1] = w_comb[k] - r_comb_dly[k];
      end
   end

`ifdef PDM_DAC_NOISE_SHAPE_EN
   if (S >= 1) begin : g_ns
      logic [S-1:0] r_resid;

      assign w_v = w_comb[ORDER] + {{(W-S){1'b0}}, r_resid};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_resid <= '0;
         end else if (i_emit) begin
            r_resid <= w_sat ? '0 : w_v[S-1:0];
         end
      end
   end else begin : g_plain
      assign w_v = w_comb[ORDER];
   end
`else
   assign w_v = w_comb[ORDER];
   if (S >= 1) begin : g_trunc
      logic w_unused_lsb;
      assign w_unused_lsb = ^w_v[S-1:0];
   end
`endif

   // Comb output never exceeds R^ORDER, so only the top bit of q can overflow.
   assign w_q   = w_v[W-1:S];
   assign w_sat = w_q[DAC_W];
   assign w_dac = w_sat ? '1 : w_q[DAC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < ORDER; k++) begin
            r_integ[k]    <= '0;
            r_comb_dly[k] <= '0;
         end
         r_dac  <= '0;
         r_clip <= 1'b0;
      end else begin
         if (i_en) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
               r_integ[k] <= w_integ_nxt[k];
            end
         end
         if (i_event) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
               r_comb_dly[k] <= w_comb[k];
            end
         end
         if (i_emit) begin
            r_dac <= w_dac;
            if (w_sat) begin
               r_clip <= 1'b1;
            end
         end
      end
   end

   assign o_dac  = r_dac;
   assign o_clip = r_clip;

endmodule

// File: rtl/pdm_dac_adapter.sv
// PDM-to-resistor-DAC adapter: per-channel CIC decimation with shared
// decimation/warm-up control. Optional macro: PDM_DAC_NOISE_SHAPE_EN.
module pdm_dac_adapter
   import pdm_dac_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DAC_W    = 4,
   parameter int unsigned R_LOG2   = 4,
   parameter int unsigned ORDER    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [CHANNELS-1:0]       pdm_in,
   output logic [CHANNELS*DAC_W-1:0] dac_out,
   output logic                      sample_valid,
   output logic [CHANNELS-1:0]       clip
);

   logic [R_LOG2-1:0]   r_dec_cnt;
   logic [WARMUP_W-1:0] r_warm;
   logic                r_valid;
   logic                w_event;
   logic                w_warm_done;
   logic                w_emit;

   assign w_event     = en && (r_dec_cnt == '1);
   assign w_warm_done = (r_warm == WARMUP_W'(ORDER));
   assign w_emit      = w_event && w_warm_done;

   // The first ORDER events only prime the comb delays and are not emitted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dec_cnt <= '0;
         r_warm    <= '0;
         r_valid   <= 1'b0;
      end else begin
         if (en) begin
            r_dec_cnt <= r_dec_cnt + R_LOG2'(1);
         end
         if (w_event && !w_warm_done) begin
            r_warm <= r_warm + WARMUP_W'(1);
         end
         r_valid <= w_emit;
      end
   end

   assign sample_valid = r_valid;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pdm_cic_channel #(
         .DAC_W  (DAC_W),
         .R_LOG2 (R_LOG2),
         .ORDER  (ORDER)
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_en    (en),
         .i_pdm   (pdm_in[c]),
         .i_event (w_event),
         .i_emit  (w_emit),
         .o_dac   (dac_out[c*DAC_W +: DAC_W]),
         .o_clip  (clip[c])
      );
   end

endmodule

// File: doc/pdm_dac_adapter.md
Name: pdm_dac_adapter

Overview:
- Converts 1-bit PDM audio streams into multi-bit samples for the board resistor DACs, replacing plain bit replication onto all DAC pins.
- Each channel has a CIC decimator of order ORDER with ratio 2^R_LOG2, followed by saturating requantisation to DAC_W bits.
- The output is held between updates.
- Sits between the demo core audio output and the 4-bit audio_l/audio_r pins.

Parameters:
- CHANNELS, 2: number of independent PDM channels.
- DAC_W, 4: output sample width per channel; 1 <= DAC_W <= ORDER*R_LOG2.
- R_LOG2, 4: log2 of the decimation ratio R; 1..8.
- ORDER, 2: CIC order; 1..3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  PDM sample strobe; pdm_in is sampled only in cycles where en=1.
- pdm_in  in  CHANNELS  PDM bits; bit c is channel c; 1 counts as +1, 0 counts as 0.
- dac_out  out  CHANNELS*DAC_W  channel c occupies bits [c*DAC_W +: DAC_W]; unsigned.
- sample_valid  out  1  one-cycle pulse when dac_out updates.
- clip  out  CHANNELS  sticky per-channel flag: saturation occurred since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - dac_out=0, sample_valid=0, clip=0.
  - All integrators, comb delays, the decimation counter and the warm-up counter are 0.
- Internal width: W = ORDER*R_LOG2+1. Integrators and combs are unsigned and wrap modulo 2^W; the wrap is intentional and exact for CIC.
- Integrators: on each en=1 cycle, integrator stage k adds stage k-1; stage 0 adds pdm_in[c]. No update when en=0.
- Decimation counter: 0..R-1, advances on en=1 and wraps to 0. The cycle with en=1 and counter=R-1 is the decimation event.
- Decimation event: the comb chain (ORDER stages, delay 1 decimated sample) evaluates from the updated last integrator value.
  - The requantised result is registered into dac_out on the next clk edge.
  - sample_valid pulses in that same next cycle.
  - Latency is 1 clk after the event cycle.
- Requantisation:
  - S = ORDER*R_LOG2 - DAC_W.
  - q = comb >> S.
  - If q > 2^DAC_W-1, then dac_out = 2^DAC_W-1 and clip[c] is set. This occurs only when every sample is 1, where comb = 2^(ORDER*R_LOG2).
- Warm-up:
  - The first ORDER decimation events after reset are suppressed: no sample_valid, dac_out stays 0.
  - A 2-bit warm-up counter saturates at ORDER.
- Channels are fully independent and share only en, the decimation counter and the warm-up counter.
- en held low: all state frozen, dac_out held, no sample_valid.
- Reset mid-window: everything clears immediately, and warm-up restarts from the first decimation event after release.

Optional Feature:
- Macro: PDM_DAC_NOISE_SHAPE_EN.
- Defined: first-order error feedback per channel.
  - v = comb + r, where r is an S-bit residual register, reset 0.
  - q = v >> S; r <= v[S-1:0] on each non-suppressed event.
  - On saturation, r <= 0.
  - Requires S >= 1. If S=0, the feature is inert.
- Undefined: plain truncation with no residual register. Output and latency are otherwise identical.

Decomposition:
- Package pdm_dac_pkg:
  - width function cic_width(ORDER,R_LOG2).
  - shift function S.
  - WARMUP_W localparam.
- Sub-module pdm_cic_channel: one channel containing integrators, combs, requantiser, residual and clip. It is instantiated CHANNELS times by generate.
- The top level holds the decimation counter, warm-up counter, en gating and the sample_valid register.

Test Plan:
1. Defaults, en=1, pdm_in=2'b11 constant -> first sample_valid on the 3rd decimation event (clk 48, counting from 0 after reset release), then every 16 clks; dac_out=8'hFF, clip=2'b11.
2. Defaults, pdm_in=2'b00 -> dac_out=0 on every valid, clip=0; sample_valid period 16.
3. Defaults, ch0 alternating 1,0 and ch1 constant 0 -> after warm-up ch0=8 (comb 128>>4), ch1=0; clip=0.
4. Defaults, en toggling every other clk, ch0 alternating 1,0 over the en=1 cycles -> sample_valid period 32 clks; ch0 value 8 unchanged; state frozen when en=0.
5. Reset asserted for one cycle mid-window after steady output -> dac_out, clip, sample_valid go to 0 asynchronously; the next valid appears only after ORDER fresh events.
6. ORDER=1, R_LOG2=4, DAC_W=2, pdm_in with 5 ones per 16-sample window:
   - Without the macro -> constant 1.
   - With PDM_DAC_NOISE_SHAPE_EN -> repeating 1,1,1,2 (mean 1.25).
